// File: rtl/uart_tx_trigger_pkg.sv
// Shared UART definitions: FSM encoding, frame width and baud divisor helper.
package uart_tx_trigger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;

  // Integer division on purpose; the receiver uses the same rounding.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while enabled, held at 0 otherwise.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_baud_gen: CLKS_PER_BIT must be >= 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || cnt_q == TC) cnt_d = '0;
    else                      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == TC);

endmodule

// File: rtl/uart_tx_trigger.sv
// One 8N1 frame of data_i per rising edge of the debounced transmit_i level.
module uart_tx_trigger
  import uart_tx_trigger_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       transmit_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 transmit_q;
  logic                 start_req, tick;

  assign start_req = transmit_i & ~transmit_q;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (state_q != ST_IDLE),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start_req) begin
          shift_d = data_i;
          state_d = ST_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_START: if (tick) begin
        state_d = ST_DATA;
        tx_d    = shift_q[0];
        idx_d   = '0;
      end
      ST_DATA: if (tick) begin
        if (idx_q == IDX_LAST) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end else begin
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
          idx_d   = idx_q + IW'(1);
        end
      end
      ST_STOP: if (tick) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // transmit_q resets high so a button held through reset cannot start a frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      transmit_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      transmit_q <= transmit_i;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_uart_tx_trigger.sv
// Frame-level model of the UART trigger checked every cycle, plus literal line-level checks.
module tb_uart_tx_trigger;

  localparam int CPB   = 8;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       transmit = 1'b1;
  logic [7:0] data = 8'h00;
  logic       tx, busy, done;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  uart_tx_trigger #(.CLK_FREQ(80), .BAUD(10)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .transmit_i (transmit),
    .data_i     (data),
    .tx_o       (tx),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Model: a frame is just a cycle count 0..FRAME-1 since the accepted rising edge.
  int         m_cyc  = -1;
  logic       m_prev = 1'b1;
  logic       m_done = 1'b0;
  logic [7:0] m_byte = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc  <= -1;
      m_prev <= 1'b1;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cyc >= 0) begin
        if (m_cyc == FRAME - 1) begin
          m_cyc  <= -1;
          m_done <= 1'b1;
        end else m_cyc <= m_cyc + 1;
      end else if (transmit && !m_prev) begin
        m_cyc  <= 0;
        m_byte <= data;
      end
      m_prev <= transmit;
    end
  end

  function automatic int exp_tx();
    int k;
    if (m_cyc < 0) return 1;
    k = m_cyc / CPB;
    if (k == 0) return 0;
    if (k == 9) return 1;
    return int'(m_byte[k-1]);
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_tx",   int'(tx),   exp_tx());
      chk("model_busy", int'(busy), (m_cyc >= 0) ? 1 : 0);
      chk("model_done", int'(done), int'(m_done));
    end
  end

  task automatic press(input logic [7:0] d);
    transmit = 1'b0;
    @(negedge clk);
    data     = d;
    transmit = 1'b1;
    @(negedge clk);
  endtask

  // Called at the negedge of frame cycle 0; line[k] is the expected level of bit slot k.
  // mode 0: plain, 1: re-press at cycle 30 with new data, 2: chain next press into done cycle, 3: reset at cycle 40.
  task automatic run_frame(input logic [9:0] line, input int mode);
    for (int c = 0; c <= FRAME; c++) begin
      if (c == 0) begin
        chk("start_tx",   int'(tx),   0);
        chk("start_busy", int'(busy), 1);
      end
      if (c % CPB == 4) chk($sformatf("midbit%0d", c / CPB), int'(tx), int'(line[c / CPB]));
      if (c == FRAME - 1) begin
        chk("busy_last_cycle", int'(busy), 1);
        chk("done_not_early",  int'(done), 0);
      end
      if (c == FRAME) begin
        chk("done_pulse", int'(done), 1);
        chk("busy_clear", int'(busy), 0);
        chk("gap_tx_idle", int'(tx), 1);
      end
      if (mode == 3 && c == 40) begin
        #1 rst = 1'b1;
        #1;
        chk("async_rst_tx",   int'(tx),   1);
        chk("async_rst_busy", int'(busy), 0);
        return;
      end
      if ((mode != 1 && c == 10) || (mode == 1 && c == 20)) transmit = 1'b0;
      if (mode == 1 && c == 30) begin
        transmit = 1'b1;
        data     = 8'h3C;
      end
      if (mode == 2 && c == FRAME) begin
        transmit = 1'b1;
        data     = 8'hFF;
      end
      if (c < FRAME) @(negedge clk);
    end
  endtask

  int act;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx",   int'(tx),   1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    cmp_en = 1'b1;
    rst = 1'b0;

    // Button held through reset release must not start a frame.
    act = 0;
    repeat (200) begin
      @(negedge clk);
      if (busy || done || !tx) act++;
    end
    chk("held_no_frame", act, 0);

    // A5 with a re-press and data change mid-frame: ignored, single frame.
    press(8'hA5);
    run_frame(10'b1101001010, 1);
    act = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy || !tx) act++;
    end
    chk("no_retrigger", act, 0);

    // 00 then FF back to back, second edge in the done cycle.
    press(8'h00);
    run_frame(10'b1000000000, 2);
    @(negedge clk);
    run_frame(10'b1111111110, 0);

    // Reset mid-frame, then silence until a fresh edge.
    repeat (5) @(negedge clk);
    press(8'h3C);
    run_frame(10'b1001111000, 3);
    @(negedge clk);
    rst = 1'b0;
    act = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy || done || !tx) act++;
    end
    chk("post_rst_quiet", act, 0);

    press(8'h5A);
    run_frame(10'b1010110100, 0);
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_trigger.md
Name: uart_tx_trigger

Overview:
- Downstream consumer of the button debouncer's debounced `transmit` level.
- Detects its rising edge and serialises one 8N1 UART frame of the `data` byte on `tx`, so one press produces exactly one frame.
- Sits between the debouncer and the board TX pin.
- Exposes `busy` and a `done` pulse for the VGA/status logic.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- CLKS_PER_BIT: local, CLK_FREQ/BAUD using integer division. CLKS_PER_BIT >= 2 is required; elaboration fails otherwise.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous active-high reset.
- transmit  input  1  debounced button level, already synchronous to clk.
- data  input  8  byte to send; sampled only at frame start.
- tx  output  1  serial line, idle high; registered output.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Clocking and reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: tx=1, busy=0, done=0, state=IDLE, baud counter=0, bit index=0, transmit_q=1.
  - Because transmit_q resets to 1, a button held through reset release does not start a frame.
- Edge detect: transmit_q <= transmit every cycle. start_req = transmit & ~transmit_q.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - On start_req: latch data into shift_reg, go to START, tx<=0, busy<=1, baud counter=0.
  - Latency: tx falls on the clock edge that samples the rising edge of transmit.
- Baud counter: counts 0..CLKS_PER_BIT-1 in every non-IDLE state. Terminal count (TC) = counter==CLKS_PER_BIT-1; at TC the counter wraps to 0.
- START: at TC, go to DATA, tx<=shift_reg[0], bit index=0.
- DATA:
  - At TC with bit index<7: shift right, tx<=next bit, bit index++.
  - At TC with bit index==7: go to STOP, tx<=1.
  - Bits go out LSB first, each for exactly CLKS_PER_BIT cycles.
- STOP: at TC, go to IDLE, busy<=0, done<=1 for exactly one cycle.
- Frame length: busy is high for exactly 10*CLKS_PER_BIT cycles.
- Edges while busy:
  - A rising edge of transmit while busy=1 is ignored, not queued. transmit_q still tracks, so a level held past frame end does not retrigger.
  - A new frame may start at the earliest in the cycle after done; done and a new start never coincide.
- data changes during a frame do not affect the frame in flight.
- Reset asserted mid-frame: immediate return to reset values (tx=1 asynchronously). No partial frame resumes.

Decomposition:
- Shared package/header uart_defs:
  - FSM state encodings (2-bit: IDLE=0, START=1, DATA=2, STOP=3).
  - DATA_BITS=8.
  - clks_per_bit(CLK_FREQ, BAUD) constant function, reused by the future uart_rx.
- One natural sub-module: uart_baud_gen.
  - Inputs: clk, rst, en (clear-while-low).
  - Output: tick at TC.
  - Parameter CLKS_PER_BIT.
- The FSM, edge detect and shift register stay in uart_tx_trigger.

Test Plan (CLK_FREQ=80, BAUD=10, so CLKS_PER_BIT=8):
- Reset with transmit=1 held, then release rst and keep transmit=1 for 200 cycles -> tx stays 1, busy=0, no done.
- transmit 0->1 with data=8'hA5 -> next edge tx=0, busy=1; then line carries 0,1,0,1,0,0,1,0,1,1, 8 cycles each; busy high 80 cycles; done high one cycle at cycle 80.
- During the A5 frame, toggle transmit 0->1 at cycle 30 and change data to 8'h3C -> ignored, single A5 frame only, no second frame after done.
- Two presses with transmit low between, second rising edge one cycle after done, data=8'h00 then 8'hFF -> two back-to-back frames, idle-high gap of at least 1 cycle, correct bits.
- Assert rst at cycle 40 of a frame -> tx=1 and busy=0 immediately (asynchronously); after release, no activity until a new rising edge.
- Bench checker samples tx mid-bit (offset 4) on every frame and compares against the data latched at start.
